weight_load_scheduler: RTL and testbench



---
 rtl/weight_load_scheduler.sv | 154 +++++++++++++++
 tb/tb_weight_load_scheduler.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/weight_load_scheduler.sv
// weight_load_scheduler: fetches WORDS_PER_CH ROM words per output channel,
// unpacks them into a 32-weight bus and presents the bus to the PE array with
// a valid/ready handshake, one channel at a time, for up to MAX_CH channels.
module weight_load_scheduler #(
    parameter int ADDR_W       = 9,
    parameter int WEIGHT_W     = 7,
    parameter int DATA_W       = 28,
    parameter int WORDS_PER_CH = 8,
    parameter int MAX_CH       = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [6:0]            num_ch,
    output logic                  rom_en,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [DATA_W-1:0]     rom_data,
    output logic [32*WEIGHT_W-1:0] w_bus,
    output logic                  w_valid,
    input  logic                  pe_ready,
    output logic [5:0]            ch_idx,
    output logic [MAX_CH-1:0]     ch_loaded,
    output logic                  busy,
    output logic                  done
);

    localparam int BUS_W = 32 * WEIGHT_W;
    localparam int K_W   = $clog2(WORDS_PER_CH + 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;

    logic [ADDR_W-1:0]  base_q;
    logic [6:0]         num_q;
    logic [K_W-1:0]     k;
    logic [5:0]         ch_q;
    logic [BUS_W-1:0]   bus_q;
    logic [MAX_CH-1:0]  loaded_q;

    logic               fetch_last;
    logic               handshake;
    logic               last_ch;
    logic [ADDR_W-1:0]  fetch_addr;
    logic [6:0]         num_sat;

    assign fetch_last = (k == K_W'(WORDS_PER_CH));
    assign handshake  = (state == PRESENT) && pe_ready;
    assign last_ch    = ({1'b0, ch_q} == (num_q - 7'd1));
    assign num_sat    = (num_ch > 7'(MAX_CH)) ? 7'(MAX_CH) : num_ch;
    assign fetch_addr = base_q + ADDR_W'(ch_q) * ADDR_W'(WORDS_PER_CH) + ADDR_W'(k);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        state_next = state;
        rom_en     = 1'b0;
        rom_addr   = '0;
        w_valid    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (num_sat == 7'd0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                if (!fetch_last) begin
                    rom_en   = 1'b1;
                    rom_addr = fetch_addr;
                end else begin
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                w_valid = 1'b1;
                if (pe_ready) begin
                    state_next = last_ch ? DONE : FETCH;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Layer latches, word/channel counters, weight unpacking and loaded mask.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q   <= '0;
            num_q    <= '0;
            k        <= '0;
            ch_q     <= '0;
            bus_q    <= '0;
            loaded_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base_q   <= base_addr;
                        num_q    <= num_sat;
                        k        <= '0;
                        ch_q     <= '0;
                        loaded_q <= '0;
                    end
                end
                FETCH: begin
                    // Read data lags the address by one cycle, so the word
                    // issued at k lands in slot k while k+1 is current.
                    for (int unsigned j = 0; j < WORDS_PER_CH; j++) begin
                        if (k == K_W'(j + 1)) begin
                            bus_q[BUS_W-1-j*DATA_W -: DATA_W] <= rom_data;
                        end
                    end
                    k <= fetch_last ? '0 : k + K_W'(1);
                end
                PRESENT: begin
                    if (handshake) begin
                        loaded_q <= {loaded_q[MAX_CH-2:0], 1'b1};
                        if (!last_ch) begin
                            ch_q <= ch_q + 6'd1;
                            k    <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_bus     = bus_q;
    assign ch_idx    = ch_q;
    assign ch_loaded = loaded_q;

endmodule

// File: tb/tb_weight_load_scheduler.sv
// Directed bench for weight_load_scheduler: table of layer runs checked
// cycle-by-cycle against a ROM whose word equals its address, plus
// hand-written reset-abort sequence.
module tb_weight_load_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [8:0]   base_addr;
    logic [6:0]   num_ch;
    logic         rom_en;
    logic [8:0]   rom_addr;
    logic [27:0]  rom_data = '0;
    logic [223:0] w_bus;
    logic         w_valid;
    logic         pe_ready;
    logic [5:0]   ch_idx;
    logic [63:0]  ch_loaded;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    weight_load_scheduler #(
        .ADDR_W(9), .WEIGHT_W(7), .DATA_W(28), .WORDS_PER_CH(8), .MAX_CH(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_ch(num_ch), .rom_en(rom_en), .rom_addr(rom_addr),
        .rom_data(rom_data), .w_bus(w_bus), .w_valid(w_valid),
        .pe_ready(pe_ready), .ch_idx(ch_idx), .ch_loaded(ch_loaded),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // ROM model: word content equals its address, one-cycle read latency.
    always @(posedge clk) begin
        if (rom_en) rom_data <= 28'(rom_addr);
    end

    typedef struct {
        int          base;
        int          num;
        int          ready_low;
        bit          poke;
        int          exp_done;
        logic [63:0] exp_mask;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [223:0] exp_bus(input int b, input int c);
        logic [223:0] r;
        logic [27:0]  word;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            word = 28'((b + 8 * c + i / 4) % 512);
            r[223 - 7 * i -: 7] = word[27 - 7 * (i % 4) -: 7];
        end
        return r;
    endfunction

    function automatic logic [63:0] mask(input int c);
        if (c >= 64) return '1;
        return (64'd1 << c) - 64'd1;
    endfunction

    task automatic run_layer(input int b, input int n, input int rl, input bit poke,
                             input int exp_done, input logic [63:0] exp_mask);
        int eff, cyc, naddr, ch, waited;
        bit seen;
        eff = (n > 64) ? 64 : n;
        @(negedge clk);
        base_addr = 9'(b); num_ch = 7'(n); start = 1'b1; pe_ready = 1'b1;
        cyc = 0; naddr = 0; ch = 0; waited = 0; seen = 0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            chk("busy", busy, 1);
            if (rom_en) begin
                chk("rom_addr", rom_addr, (b + naddr) % 512);
                naddr++;
            end
            if (w_valid) begin
                chk("ch_idx", ch_idx, ch);
                chk("w_bus", w_bus, exp_bus(b, ch));
                chk("ch_loaded_mid", ch_loaded, mask(ch));
                if (waited < rl) begin
                    pe_ready = 1'b0;
                    if (poke && waited == 0 && ch == 0) begin
                        start = 1'b1; base_addr = 9'd200; num_ch = 7'd1;
                    end
                    waited++;
                end else begin
                    pe_ready = 1'b1;
                    ch++;
                    waited = 0;
                end
            end
            if (done) seen = 1;
        end
        start = 1'b0;
        chk("done_cycle", cyc, exp_done);
        chk("rom_reads", naddr, 8 * eff);
        chk("channels", ch, eff);
        chk("ch_loaded", ch_loaded, exp_mask);
        @(negedge clk);
        chk("done_once", done, 0);
        chk("busy_after", busy, 0);
        chk("w_valid_after", w_valid, 0);
        chk("rom_en_after", rom_en, 0);
        chk("ch_loaded_kept", ch_loaded, exp_mask);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rom_en"}, rom_en, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_w_bus"}, w_bus, 0);
        chk({tag, "_w_valid"}, w_valid, 0);
        chk({tag, "_ch_idx"}, ch_idx, 0);
        chk({tag, "_ch_loaded"}, ch_loaded, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        int cyc;
        // base, num, ready_low, poke, done cycle, final mask
        vecs[0] = '{0,   64,  0, 1'b0, 641, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[1] = '{0,   2,   5, 1'b0, 31,  64'h3};
        vecs[2] = '{508, 1,   0, 1'b0, 11,  64'h1};
        vecs[3] = '{0,   0,   0, 1'b0, 1,   64'h0};
        vecs[4] = '{16,  2,   3, 1'b1, 27,  64'h3};
        vecs[5] = '{100, 100, 0, 1'b0, 641, 64'hFFFF_FFFF_FFFF_FFFF};

        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_ch = '0; pe_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_layer(vecs[v].base, vecs[v].num, vecs[v].ready_low, vecs[v].poke,
                      vecs[v].exp_done, vecs[v].exp_mask);
        end

        // Abort in the middle of channel 3's fetch, then restart one channel.
        @(negedge clk);
        base_addr = 9'd0; num_ch = 7'd8; start = 1'b1; pe_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(rom_en && rom_addr == 9'd26) && cyc < 200) begin
            chk("abort_no_done", done, 0);
            @(negedge clk);
            cyc++;
        end
        chk("abort_reach_ch3", ch_idx, 3);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("abort");
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_idle_done", done, 0);
            chk("abort_idle_busy", busy, 0);
        end
        run_layer(0, 1, 0, 1'b0, 11, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
